// File: rtl/datapath_mac.sv
// datapath_mac: fixed-point multiply/accumulate datapath stepped by an external sequencer.
// Define DATAPATH_SAT_EN for saturating reductions with a sticky ovf flag; otherwise results wrap.
module datapath_mac #(
  parameter int unsigned   DW   = 16,
  parameter int unsigned   FRAC = 8,
  parameter logic [DW-1:0] K0   = 16'h0100,
  parameter logic [DW-1:0] K1   = 16'h0100,
  parameter logic [DW-1:0] K2   = 16'h0100,
  parameter logic [DW-1:0] K3   = 16'h0100,
  parameter logic [DW-1:0] K4   = 16'h0100,
  parameter logic [DW-1:0] K5   = 16'h0100
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic [DW-1:0] x_in,
  input  logic          x_valid,
  input  logic [2:0]    sel_const,
  input  logic [1:0]    sel_fun,
  input  logic [1:0]    sel_acum,
  input  logic          senal,
  input  logic          band_listo,
  output logic          bandera,
  output logic          busy,
  output logic [DW-1:0] y_out,
  output logic          y_valid,
  output logic          overrun,
  output logic          ovf
);

  logic [DW-1:0]          x_reg, acc, z_reg, y_prev;
  logic [DW-1:0]          k_sel, a_op, p, sum_red, acc_next;
  logic signed [2*DW-1:0] prod;
  logic                   accept, busy_next;

  always_comb begin
    k_sel = '0;
    case (sel_const)
      3'd0:    k_sel = K0;
      3'd1:    k_sel = K1;
      3'd2:    k_sel = K2;
      3'd3:    k_sel = K3;
      3'd4:    k_sel = K4;
      3'd5:    k_sel = K5;
      default: k_sel = '0;
    endcase
  end

  always_comb begin
    a_op = x_reg;
    case (sel_fun)
      2'b00: a_op = x_reg;
      2'b01: a_op = z_reg;
      2'b10: a_op = acc;
      2'b11: a_op = y_prev;
      default: a_op = x_reg;
    endcase
  end

  assign prod = $signed(a_op) * $signed(k_sel);

`ifdef DATAPATH_SAT_EN
  localparam logic [DW-1:0] MAX_POS = {1'b0, {(DW-1){1'b1}}};
  localparam logic [DW-1:0] MAX_NEG = {1'b1, {(DW-1){1'b0}}};

  logic signed [2*DW-1:0] p_wide;
  logic [DW:0]            sum_wide;
  logic                   p_sat, sum_sat, ovf_hit;

  // A value fits in DW bits only if everything from bit DW-1 upward is pure sign extension.
  assign p_wide   = prod >>> FRAC;
  assign p_sat    = (p_wide[2*DW-1:DW-1] != '0) && (p_wide[2*DW-1:DW-1] != '1);
  assign p        = p_sat ? (p_wide[2*DW-1] ? MAX_NEG : MAX_POS) : p_wide[DW-1:0];
  assign sum_wide = {acc[DW-1], acc} + {p[DW-1], p};
  assign sum_sat  = sum_wide[DW] != sum_wide[DW-1];
  assign sum_red  = sum_sat ? (sum_wide[DW] ? MAX_NEG : MAX_POS) : sum_wide[DW-1:0];
  assign ovf_hit  = ((sel_acum == 2'b00) && (p_sat || sum_sat)) ||
                    ((sel_acum == 2'b01) && p_sat);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)       ovf <= 1'b0;
    else if (ovf_hit) ovf <= 1'b1;
  end
`else
  assign p       = DW'(prod >>> FRAC);
  assign sum_red = acc + p;
  assign ovf     = 1'b0;
`endif

  always_comb begin
    acc_next = acc;
    case (sel_acum)
      2'b00:   acc_next = sum_red;
      2'b01:   acc_next = p;
      2'b10:   acc_next = '0;
      default: acc_next = acc;
    endcase
  end

  // A finishing step frees the datapath in the same edge, so a coincident sample is taken.
  assign accept    = x_valid && (!busy || band_listo);
  assign busy_next = accept ? 1'b1 : (band_listo ? 1'b0 : busy);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      x_reg   <= '0;
      acc     <= '0;
      z_reg   <= '0;
      y_prev  <= '0;
      y_out   <= '0;
      bandera <= 1'b0;
      busy    <= 1'b0;
      y_valid <= 1'b0;
      overrun <= 1'b0;
    end else begin
      if (accept) x_reg <= x_in;
      bandera <= accept;
      busy    <= busy_next;
      y_valid <= band_listo;
      if (x_valid && busy && !band_listo) overrun <= 1'b1;
      acc <= acc_next;
      if (senal) z_reg <= acc;
      if (band_listo) begin
        y_out  <= acc_next;
        y_prev <= acc_next;
      end
    end
  end

endmodule

// File: tb/tb_datapath_mac.sv
// Self-checking bench for datapath_mac: directed scenarios plus randomized traffic against an integer model.
module tb_datapath_mac;

`ifdef DATAPATH_SAT_EN
  localparam bit SAT = 1'b1;
`else
  localparam bit SAT = 1'b0;
`endif

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic [15:0] x_in = '0;
  logic        x_valid = 1'b0;
  logic [2:0]  sel_const = '0;
  logic [1:0]  sel_fun = '0;
  logic [1:0]  sel_acum = 2'b11;
  logic        senal = 1'b0;
  logic        band_listo = 1'b0;
  logic        bandera, busy, y_valid, overrun, ovf;
  logic [15:0] y_out;

  int checks = 0;
  int errors = 0;

  // Reference model state, held as signed integers
  int m_x, m_acc, m_z, m_yp, m_y;
  bit m_busy, m_band, m_yv, m_ovr, m_ovf;
  int kv[6] = '{128, 256, -256, 384, 16384, 32767};

  datapath_mac #(
    .DW(16), .FRAC(8),
    .K0(16'h0080), .K1(16'h0100), .K2(16'hFF00),
    .K3(16'h0180), .K4(16'h4000), .K5(16'h7FFF)
  ) dut (
    .clk(clk), .rst_n(rst_n), .x_in(x_in), .x_valid(x_valid),
    .sel_const(sel_const), .sel_fun(sel_fun), .sel_acum(sel_acum),
    .senal(senal), .band_listo(band_listo), .bandera(bandera), .busy(busy),
    .y_out(y_out), .y_valid(y_valid), .overrun(overrun), .ovf(ovf)
  );

  always #5 clk = ~clk;

  function automatic int red(input int v, output bit hit);
    hit = 1'b0;
    if (SAT) begin
      if (v > 32767)  begin hit = 1'b1; return 32767;  end
      if (v < -32768) begin hit = 1'b1; return -32768; end
      return v;
    end
    return ((v + 32768) & 65535) - 32768;
  endfunction

  task automatic model_reset();
    m_x = 0; m_acc = 0; m_z = 0; m_yp = 0; m_y = 0;
    m_busy = 0; m_band = 0; m_yv = 0; m_ovr = 0; m_ovf = 0;
  endtask

  task automatic model_update();
    int k, a, p, nacc;
    bit h1, h2, acc_ok;
    k = (sel_const < 3'd6) ? kv[sel_const] : 0;
    case (sel_fun)
      2'b00:   a = m_x;
      2'b01:   a = m_z;
      2'b10:   a = m_acc;
      default: a = m_yp;
    endcase
    p = red((a * k) >>> 8, h1);
    h2 = 1'b0;
    case (sel_acum)
      2'b00:   nacc = red(m_acc + p, h2);
      2'b01:   nacc = p;
      2'b10:   nacc = 0;
      default: nacc = m_acc;
    endcase
    if ((sel_acum == 2'b00 && (h1 || h2)) || (sel_acum == 2'b01 && h1)) m_ovf = 1'b1;
    acc_ok = x_valid && (!m_busy || band_listo);
    if (x_valid && m_busy && !band_listo) m_ovr = 1'b1;
    if (senal) m_z = m_acc;
    if (band_listo) begin m_y = nacc; m_yp = nacc; end
    m_yv = band_listo;
    m_band = acc_ok;
    if (acc_ok) m_x = int'($signed(x_in));
    if (acc_ok) m_busy = 1'b1;
    else if (band_listo) m_busy = 1'b0;
    m_acc = nacc;
  endtask

  task automatic cycle(input logic xv, input logic [15:0] xi, input logic [1:0] fun,
                       input logic [2:0] kc, input logic [1:0] ac, input logic sn, input logic bl);
    x_valid = xv; x_in = xi; sel_fun = fun; sel_const = kc;
    sel_acum = ac; senal = sn; band_listo = bl;
    model_update();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    model_reset();
    repeat (2) @(posedge clk);
    #1;
    checks += 6;
    if (bandera !== 1'b0) begin errors++; $display("FAIL rst_bandera got %b exp 0", bandera); end
    if (busy !== 1'b0)    begin errors++; $display("FAIL rst_busy got %b exp 0", busy); end
    if (y_out !== 16'h0)  begin errors++; $display("FAIL rst_y_out got %h exp 0000", y_out); end
    if (y_valid !== 1'b0) begin errors++; $display("FAIL rst_y_valid got %b exp 0", y_valid); end
    if (overrun !== 1'b0) begin errors++; $display("FAIL rst_overrun got %b exp 0", overrun); end
    if (ovf !== 1'b0)     begin errors++; $display("FAIL rst_ovf got %b exp 0", ovf); end
    rst_n = 1'b1;
  endtask

  task automatic test_multiply();
    cycle(1'b1, 16'h0400, 2'b00, 3'd0, 2'b11, 1'b0, 1'b0);
    checks += 2;
    if (bandera !== 1'b1) begin errors++; $display("FAIL mul_bandera got %b exp 1", bandera); end
    if (busy !== 1'b1)    begin errors++; $display("FAIL mul_busy got %b exp 1", busy); end
    cycle(1'b0, 16'h0000, 2'b00, 3'd0, 2'b01, 1'b0, 1'b0);
    checks += 2;
    if (dut.acc !== 16'h0200) begin errors++; $display("FAIL mul_acc got %h exp 0200", dut.acc); end
    if (bandera !== 1'b0)     begin errors++; $display("FAIL mul_bandera_pulse got %b exp 0", bandera); end
    cycle(1'b0, 16'h0000, 2'b00, 3'd0, 2'b11, 1'b1, 1'b0);
  endtask

  task automatic test_saturation();
    logic [15:0] exp_acc;
    cycle(1'b1, 16'h7F00, 2'b00, 3'd0, 2'b11, 1'b0, 1'b1);
    checks += 2;
    if (y_out !== 16'h0200) begin errors++; $display("FAIL sat_prep_y_out got %h exp 0200", y_out); end
    if (bandera !== 1'b1)   begin errors++; $display("FAIL sat_prep_bandera got %b exp 1", bandera); end
    cycle(1'b0, 16'h0000, 2'b00, 3'd1, 2'b01, 1'b0, 1'b0);
    checks += 2;
    if (dut.acc !== 16'h7F00) begin errors++; $display("FAIL sat_load_acc got %h exp 7F00", dut.acc); end
    if (y_valid !== 1'b0)     begin errors++; $display("FAIL sat_y_valid got %b exp 0", y_valid); end
    cycle(1'b0, 16'h0000, 2'b01, 3'd1, 2'b00, 1'b0, 1'b0);
    exp_acc = SAT ? 16'h7FFF : 16'h8100;
    checks += 2;
    if (dut.acc !== exp_acc) begin errors++; $display("FAIL sat_acc got %h exp %h", dut.acc, exp_acc); end
    if (ovf !== SAT)         begin errors++; $display("FAIL sat_ovf got %b exp %b", ovf, SAT); end
  endtask

  task automatic test_null_coef();
    cycle(1'b0, 16'h0000, 2'b01, 3'd3, 2'b01, 1'b0, 1'b0);
    checks++;
    if (dut.acc !== 16'h0300) begin errors++; $display("FAIL null_load got %h exp 0300", dut.acc); end
    for (int i = 6; i < 8; i++) begin
      cycle(1'b0, 16'h0000, 2'($urandom_range(3)), 3'(i), 2'b00, 1'b0, 1'b0);
      checks++;
      if (dut.acc !== 16'h0300) begin errors++; $display("FAIL null_k%0d got %h exp 0300", i, dut.acc); end
    end
  endtask

  task automatic test_overrun();
    cycle(1'b1, 16'h0555, 2'b00, 3'd0, 2'b11, 1'b0, 1'b0);
    checks += 3;
    if (bandera !== 1'b0) begin errors++; $display("FAIL ovr_bandera got %b exp 0", bandera); end
    if (overrun !== 1'b1) begin errors++; $display("FAIL ovr_flag got %b exp 1", overrun); end
    if (busy !== 1'b1)    begin errors++; $display("FAIL ovr_busy got %b exp 1", busy); end
    cycle(1'b0, 16'h0000, 2'b00, 3'd1, 2'b01, 1'b0, 1'b0);
    checks++;
    if (dut.acc !== 16'h7F00) begin errors++; $display("FAIL ovr_x_reg got %h exp 7F00", dut.acc); end
  endtask

  task automatic test_finish();
    cycle(1'b1, 16'h0321, 2'b00, 3'd0, 2'b11, 1'b0, 1'b1);
    cycle(1'b0, 16'h0000, 2'b00, 3'd1, 2'b01, 1'b0, 1'b1);
    checks += 3;
    if (y_out !== 16'h0321) begin errors++; $display("FAIL fin_y_out got %h exp 0321", y_out); end
    if (y_valid !== 1'b1)   begin errors++; $display("FAIL fin_y_valid got %b exp 1", y_valid); end
    if (busy !== 1'b0)      begin errors++; $display("FAIL fin_busy got %b exp 0", busy); end
    cycle(1'b0, 16'h0000, 2'b11, 3'd1, 2'b01, 1'b0, 1'b0);
    checks += 2;
    if (dut.acc !== 16'h0321) begin errors++; $display("FAIL fin_y_prev got %h exp 0321", dut.acc); end
    if (y_valid !== 1'b0)     begin errors++; $display("FAIL fin_y_valid_pulse got %b exp 0", y_valid); end
  endtask

  task automatic test_random();
    for (int n = 0; n < 400; n++) begin
      cycle(($urandom_range(3) == 0), 16'($urandom), 2'($urandom_range(3)), 3'($urandom_range(7)),
            2'($urandom_range(3)), 1'($urandom_range(1)), ($urandom_range(5) == 0));
      checks += 7;
      if (dut.acc !== 16'(m_acc)) begin errors++; $display("FAIL rnd_acc n=%0d got %h exp %h", n, dut.acc, 16'(m_acc)); end
      if (y_out !== 16'(m_y))     begin errors++; $display("FAIL rnd_y_out n=%0d got %h exp %h", n, y_out, 16'(m_y)); end
      if (busy !== m_busy)        begin errors++; $display("FAIL rnd_busy n=%0d got %b exp %b", n, busy, m_busy); end
      if (bandera !== m_band)     begin errors++; $display("FAIL rnd_bandera n=%0d got %b exp %b", n, bandera, m_band); end
      if (y_valid !== m_yv)       begin errors++; $display("FAIL rnd_y_valid n=%0d got %b exp %b", n, y_valid, m_yv); end
      if (overrun !== m_ovr)      begin errors++; $display("FAIL rnd_overrun n=%0d got %b exp %b", n, overrun, m_ovr); end
      if (ovf !== m_ovf)          begin errors++; $display("FAIL rnd_ovf n=%0d got %b exp %b", n, ovf, m_ovf); end
    end
  endtask

  task automatic test_reset_mid();
    cycle(1'b1, 16'h1234, 2'b00, 3'd0, 2'b11, 1'b0, 1'b1);
    cycle(1'b0, 16'h0000, 2'b00, 3'd1, 2'b01, 1'b0, 1'b0);
    checks += 2;
    if (busy !== 1'b1)        begin errors++; $display("FAIL rmid_busy got %b exp 1", busy); end
    if (dut.acc !== 16'h1234) begin errors++; $display("FAIL rmid_acc got %h exp 1234", dut.acc); end
    sel_acum = 2'b11;
    #2 rst_n = 1'b0;
    model_reset();
    #1;
    checks += 7;
    if (dut.acc !== 16'h0) begin errors++; $display("FAIL rmid_acc_clr got %h exp 0000", dut.acc); end
    if (bandera !== 1'b0)  begin errors++; $display("FAIL rmid_bandera got %b exp 0", bandera); end
    if (busy !== 1'b0)     begin errors++; $display("FAIL rmid_busy_clr got %b exp 0", busy); end
    if (y_out !== 16'h0)   begin errors++; $display("FAIL rmid_y_out got %h exp 0000", y_out); end
    if (y_valid !== 1'b0)  begin errors++; $display("FAIL rmid_y_valid got %b exp 0", y_valid); end
    if (overrun !== 1'b0)  begin errors++; $display("FAIL rmid_overrun got %b exp 0", overrun); end
    if (ovf !== 1'b0)      begin errors++; $display("FAIL rmid_ovf got %b exp 0", ovf); end
    @(posedge clk);
    #2 rst_n = 1'b1;
    cycle(1'b1, 16'h00AA, 2'b00, 3'd0, 2'b11, 1'b0, 1'b0);
    checks += 2;
    if (bandera !== 1'b1) begin errors++; $display("FAIL rmid_accept_bandera got %b exp 1", bandera); end
    if (busy !== 1'b1)    begin errors++; $display("FAIL rmid_accept_busy got %b exp 1", busy); end
    cycle(1'b0, 16'h0000, 2'b00, 3'd1, 2'b01, 1'b0, 1'b0);
    checks += 2;
    if (bandera !== 1'b0)     begin errors++; $display("FAIL rmid_pulse got %b exp 0", bandera); end
    if (dut.acc !== 16'h00AA) begin errors++; $display("FAIL rmid_x_reg got %h exp 00AA", dut.acc); end
  endtask

  initial begin
    test_reset();
    test_multiply();
    test_saturation();
    test_null_coef();
    test_overrun();
    test_finish();
    test_random();
    test_reset_mid();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
